// File: rtl/div_pkg.sv
// Shared definitions for the unsigned divider arbiter: state encoding, default widths
// and a small index wrap helper.
package div_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_M = 4;
    localparam int DEF_R = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

    // (a + b) mod r for operands already below r
    function automatic int wrap_add(input int a, input int b, input int r);
        int s;
        s = a + b;
        if (s >= r) s = s - r;
        return s;
    endfunction

endpackage

// File: rtl/unsigned_div_arbiter_if.sv
// Requester and divider-side bundle of the shared divider arbiter.
// slave is the arbiter's view; master is the requesters/divider side.
interface unsigned_div_arbiter_if #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int R = 4
);
    logic [R-1:0]   req;
    logic [R*N-1:0] req_dividend;
    logic [R*M-1:0] req_divisor;
    logic [R-1:0]   grant;
    logic [R-1:0]   done;
    logic [N-1:0]   quotient;
    logic [M-1:0]   remainder;
    logic           dz;
    logic           div_start;
    logic [N-1:0]   div_dividend;
    logic [M-1:0]   div_divisor;
    logic           div_ready;
    logic [N-1:0]   div_quotient;
    logic [M-1:0]   div_remainder;

    modport slave (
        input  req, req_dividend, req_divisor, div_ready, div_quotient, div_remainder,
        output grant, done, quotient, remainder, dz, div_start, div_dividend, div_divisor
    );

    modport master (
        output req, req_dividend, req_divisor, div_ready, div_quotient, div_remainder,
        input  grant, done, quotient, remainder, dz, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to 0.
module div_rr_pick
    import div_pkg::*;
#(
    parameter int R  = DEF_R,
    parameter int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = R - 1; k >= 0; k--) begin
            cand = IW'(wrap_add(int'(ptr), k, R));
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/unsigned_div_arbiter.sv
// Round-robin arbiter sharing one sequential unsigned divider among R requesters.
// Zero divisors are answered locally without starting the divider.
module unsigned_div_arbiter
    import div_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int M  = DEF_M,
    parameter int R  = DEF_R,
    parameter int IW = $clog2(R)
) (
    input  logic                   clk,
    input  logic                   reset,
    unsigned_div_arbiter_if.slave  bus
);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          accept;
    logic          zero_div;
    logic          div_start_c;
    logic [R-1:0]  pick_oh;
    logic [R-1:0]  done_c;
    logic [R-1:0]  grant_q;
    logic [N-1:0]  sel_dividend;
    logic [M-1:0]  sel_divisor;
    logic [N-1:0]  quotient_q;
    logic [M-1:0]  remainder_q;
    logic          dz_q;
    logic [N-1:0]  div_dividend_q;
    logic [M-1:0]  div_divisor_q;

    div_rr_pick #(.R(R), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pick_oh      = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < R; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_oh[i]   = 1'b1;
                sel_dividend = bus.req_dividend[i*N +: N];
                sel_divisor  = bus.req_divisor[i*M +: M];
            end
        end
    end

    assign zero_div = (sel_divisor == '0);
    assign accept   = (state == IDLE) && pick_any && bus.div_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        div_start_c = 1'b0;
        done_c      = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = zero_div ? RESP : ISSUE;
            end
            ISSUE: begin
                div_start_c = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (bus.div_ready) state_nxt = RESP;
            end
            RESP: begin
                for (int i = 0; i < R; i++) done_c[i] = (IW'(i) == idx);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers change only on the edge into RESP, so they stay put between dones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr            <= '0;
            idx            <= '0;
            grant_q        <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            dz_q           <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            grant_q <= '0;
            if (accept) begin
                grant_q        <= pick_oh;
                idx            <= pick_idx;
                div_dividend_q <= sel_dividend;
                div_divisor_q  <= sel_divisor;
                if (zero_div) begin
                    quotient_q  <= '1;
                    remainder_q <= sel_dividend[M-1:0];
                    dz_q        <= 1'b1;
                end
            end
            if (state == WAIT && bus.div_ready) begin
                quotient_q  <= bus.div_quotient;
                remainder_q <= bus.div_remainder;
                dz_q        <= 1'b0;
            end
            if (state == RESP) begin
                ptr <= (idx == IW'(R - 1)) ? '0 : idx + IW'(1);
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_c;
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;
    assign bus.dz           = dz_q;
    assign bus.div_start    = div_start_c;
    assign bus.div_dividend = div_dividend_q;
    assign bus.div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_unsigned_div_arbiter.sv
// Scoreboard bench for unsigned_div_arbiter with a behavioural N-cycle divider.
module tb_unsigned_div_arbiter;

    localparam int N = 8;
    localparam int M = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    unsigned_div_arbiter_if #(.N(N), .M(M), .R(R)) bus ();

    unsigned_div_arbiter #(.N(N), .M(M), .R(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Divider model: busy for N cycles after start, result held until next start.
    int           dcnt;
    logic [N-1:0] mq;
    logic [M-1:0] mr;
    logic         hold_low = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= 0;
            mq   <= '0;
            mr   <= '0;
        end else if (bus.div_start) begin
            dcnt <= N;
            if (bus.div_divisor != 0) begin
                mq <= N'(bus.div_dividend / bus.div_divisor);
                mr <= M'(bus.div_dividend % bus.div_divisor);
            end
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end

    assign bus.div_ready     = (dcnt == 0) && !hold_low;
    assign bus.div_quotient  = mq;
    assign bus.div_remainder = mr;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    typedef struct {
        int idx;
        int cyc;
        int q;
        int r;
        int dz;
        int start;
        int dvd;
        int dvs;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (bus.div_start) begin
                start_cnt++;
                chk("start_with_grant", int'(bus.grant != 0), 1);
            end
            if (bus.grant != 0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", int'(bus.grant), 0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_vec", int'(bus.grant), 1 << e.idx);
                    chk("grant_cycle", cyc, e.cyc);
                    chk("grant_start", int'(bus.div_start), e.start);
                    if (e.start != 0) begin
                        chk("div_dividend", int'(bus.div_dividend), e.dvd);
                        chk("div_divisor", int'(bus.div_divisor), e.dvs);
                    end
                end
            end
            if (bus.done != 0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", int'(bus.done), 0);
                end else begin
                    e = dq.pop_front();
                    chk("done_vec", int'(bus.done), 1 << e.idx);
                    chk("done_cycle", cyc, e.cyc);
                    chk("quotient", int'(bus.quotient), e.q);
                    chk("remainder", int'(bus.remainder), e.r);
                    chk("dz", int'(bus.dz), e.dz);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int dvd, input int dvs);
        bus.req_dividend[i*N +: N] = N'(dvd);
        bus.req_divisor[i*M +: M]  = M'(dvs);
    endtask

    task automatic push(input int i, input int t, input int dvd, input int dvs,
                        input int q, input int r, input int dz, input bit with_done);
        exp_t e;
        e.idx   = i;
        e.cyc   = t + 1;
        e.start = (dvs != 0) ? 1 : 0;
        e.dvd   = dvd;
        e.dvs   = dvs;
        e.q     = q;
        e.r     = r;
        e.dz    = dz;
        gq.push_back(e);
        if (with_done) begin
            e.cyc = (dvs != 0) ? t + N + 3 : t + 1;
            dq.push_back(e);
        end
    endtask

    task automatic wait_grant(input int i);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.grant[i]) return;
        end
        chk("grant_timeout", int'(bus.grant[i]), 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            tick();
            if (dq.size() == 0 && gq.size() == 0) break;
        end
        chk("drain", dq.size() + gq.size(), 0);
    endtask

    task automatic do_op(input int i, input int dvd, input int dvs,
                         input int q, input int r, input int dz);
        set_ops(i, dvd, dvs);
        bus.req[i] = 1'b1;
        push(i, cyc, dvd, dvs, q, r, dz, 1'b1);
        wait_grant(i);
        bus.req[i] = 1'b0;
        wait_drain();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_quotient"}, int'(bus.quotient), 0);
        chk({tag, "_remainder"}, int'(bus.remainder), 0);
        chk({tag, "_dz"}, int'(bus.dz), 0);
        chk({tag, "_div_start"}, int'(bus.div_start), 0);
        chk({tag, "_div_dividend"}, int'(bus.div_dividend), 0);
        chk({tag, "_div_divisor"}, int'(bus.div_divisor), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ng;
        int sc;
        reset            = 1'b1;
        bus.req          = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        tick();
        tick();

        // Contention: all four requesting 255/15 from ptr=0.
        for (int i = 0; i < R; i++) set_ops(i, 255, 15);
        t = cyc;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) push(k % R, t + 12 * k, 255, 15, 17, 0, 0, 1'b1);
        ng = 0;
        for (int k = 0; k < 80 && ng < 5; k++) begin
            tick();
            if (bus.grant != 0) ng++;
        end
        chk("contention_grants", ng, 5);
        bus.req = '0;
        wait_drain();

        do_op(2, 200, 7, 28, 4, 0);

        sc = start_cnt;
        do_op(1, 93, 0, 255, 13, 1);
        chk("zero_no_start", start_cnt, sc);

        // Fairness: serve 3, then 0 and 3 together -> 0 first, then 3.
        do_op(3, 77, 4, 19, 1, 0);
        set_ops(0, 50, 5);
        set_ops(3, 90, 7);
        t = cyc;
        bus.req = 4'b1001;
        push(0, t, 50, 5, 10, 0, 0, 1'b1);
        push(3, t + 12, 90, 7, 12, 6, 0, 1'b1);
        ng = 0;
        for (int k = 0; k < 40 && ng < 2; k++) begin
            tick();
            if (bus.grant != 0) ng++;
        end
        chk("fair_grants", ng, 2);
        bus.req = '0;
        wait_drain();

        // Reset while the divider is busy: no done for the aborted operation.
        set_ops(2, 60, 7);
        t = cyc;
        bus.req[2] = 1'b1;
        push(2, t, 60, 7, 0, 0, 0, 1'b0);
        wait_grant(2);
        bus.req[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (cyc >= t + 5) break;
            tick();
        end
        chk("reset_point", cyc, t + 5);
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        do_op(0, 100, 3, 33, 1, 0);

        // Divider not ready: request must wait.
        hold_low = 1'b1;
        set_ops(0, 9, 2);
        bus.req[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("no_grant_ready_low", int'(bus.grant), 0);
        end
        hold_low = 1'b0;
        t = cyc;
        push(0, t, 9, 2, 4, 1, 0, 1'b1);
        wait_grant(0);
        bus.req[0] = 1'b0;
        wait_drain();

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
